// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared constants and helpers for the 4x4 keypad scanner.
//   KEY_W        width of a reported key code
//   KEY_NONE     5-bit candidate sentinel meaning "no single key closed"
//   COL_PATTERN  active-low column drive for column index 0..3
//   key_from_snapshot()  one-hot 16-bit frame snapshot -> candidate code
package keypad_scan_pkg;

  localparam int KEY_W = 4;

  localparam logic [4:0] KEY_NONE = 5'h10;

  localparam logic [3:0] COL_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Exactly one closed contact yields its bit index; none or several
  // (ghosting) yield KEY_NONE.
  function automatic logic [4:0] key_from_snapshot(input logic [15:0] snap);
    logic [4:0] res;
    int         hits;
    res  = KEY_NONE;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        hits = hits + 1;
        res  = 5'(i);
      end
    end
    if (hits != 1) begin
      res = KEY_NONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2_bus.sv
// sync2_bus: two-flop synchroniser for a small bus of slow asynchronous
// inputs (keypad rows, switches). Each bit is synchronised independently.
//   clk    system clock
//   rst_n  asynchronous active-low reset, flops load RST_VAL
//   d      asynchronous input bus
//   q      synchronised output bus
module sync2_bus #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and a
// valid/ack holding register for key events.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row        keypad rows, active-low, asynchronous
//   col        one-hot active-low column drive
//   key_code   code of the held event (col_index*4 + row_index)
//   key_valid  key_code holds an unconsumed event
//   key_ack    consumer accepts key_code (ignored while key_valid=0)
//   key_down   debounced "a single key is pressed" level
//   overrun    sticky: an event was dropped because key_valid was not acked
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 65536,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_down,
  output logic             overrun
);

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_MAX   = 4'(DEBOUNCE_CNT);

  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       idx;
  logic [15:0]      snapshot;
  logic [15:0]      snap_full;
  logic             frame_end;
  logic [4:0]       cand;
  logic [4:0]       prev_cand;
  logic [3:0]       stable_cnt;
  logic [3:0]       stable_next;
  logic             reported;
  logic             press_evt;
  logic             release_evt;

  sync2_bus #(
    .W       (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_sync)
  );

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      snapshot <= '0;
    end else if (tick) begin
      snapshot[{idx, 2'b00} +: 4] <= ~row_sync;
      idx                         <= idx + 2'd1;
    end
  end

  assign col = COL_PATTERN[idx];

  // The column-3 sample lands in the snapshot on the same edge the frame is
  // evaluated, so splice it in combinationally.
  assign frame_end = tick && (idx == 2'd3);
  assign snap_full = {~row_sync, snapshot[11:0]};
  assign cand      = key_from_snapshot(snap_full);

  always_comb begin
    stable_next = 4'd1;
    if (cand == prev_cand) begin
      stable_next = (stable_cnt >= DB_MAX) ? DB_MAX : stable_cnt + 4'd1;
    end
  end

  // A stable key only reports while nothing is reported, so a direct
  // key-to-key change stays silent until a release has been accepted.
  assign press_evt   = frame_end && (stable_next == DB_MAX) && (cand != KEY_NONE) && !reported;
  assign release_evt = frame_end && (stable_next == DB_MAX) && (cand == KEY_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand  <= KEY_NONE;
      stable_cnt <= 4'd0;
      reported   <= 1'b0;
      key_down   <= 1'b0;
    end else if (frame_end) begin
      prev_cand  <= cand;
      stable_cnt <= stable_next;
      if (press_evt) begin
        reported <= 1'b1;
        key_down <= 1'b1;
      end else if (release_evt) begin
        reported <= 1'b0;
        key_down <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (press_evt) begin
      if (!key_valid) begin
        key_code  <= cand[KEY_W-1:0];
        key_valid <= 1'b1;
      end else if (key_ack) begin
        key_code <= cand[KEY_W-1:0];
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4 and
// DEBOUNCE_CNT=2 (16-cycle frames). A behavioural keypad matrix drives the
// rows from the column drive; expected key codes are queued when a press is
// applied and popped when key_valid is observed.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  logic [15:0] keys;
  int          edge_n;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q [$];
  logic [3:0]  col_model [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Key k sits at column k/4 (driven on col bit 3-k/4) and row bit k%4.
  always_comb begin
    row = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && (col[3 - k / 4] == 1'b0)) row[k % 4] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic flags(input string tag, input logic v, input logic d, input logic o);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(v));
    chk({tag, ".key_down"},  32'(key_down),  32'(d));
    chk({tag, ".overrun"},   32'(overrun),   32'(o));
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed event %0h expected none queued", tag, key_code);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(key_code), 32'(e));
    end
  endtask

  task automatic goto_edge(input int t);
    int guard;
    guard = 0;
    while (edge_n < t && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_n < t) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: observed edge %0d expected edge %0d", edge_n, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    keys    = '0;
    key_ack = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.col", 32'(col), 32'h7);
    chk("rst.key_code", 32'(key_code), 32'h0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle scanning
    for (int n = 1; n <= 80; n++) begin
      goto_edge(n);
      chk("idle.col", 32'(col), 32'(col_model[(edge_n / 4) % 4]));
      if (n % 16 == 0) flags("idle", 1'b0, 1'b0, 1'b0);
    end

    // press code 6, accepted at second frame end, acked 3 cycles later
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    goto_edge(111);
    chk("p6.early_valid", 32'(key_valid), 32'h0);
    goto_edge(112);
    flags("p6", 1'b1, 1'b1, 1'b0);
    pop_chk("p6.code");
    goto_edge(115);
    key_ack = 1'b1;
    goto_edge(116);
    key_ack = 1'b0;
    chk("p6.ack_valid", 32'(key_valid), 32'h0);
    for (int f = 8; f <= 17; f++) begin
      goto_edge(16 * f);
      flags("p6.hold", 1'b0, 1'b1, 1'b0);
    end

    // release, then press code 12
    keys = '0;
    goto_edge(303);
    chk("rel6.down_pre", 32'(key_down), 32'h1);
    goto_edge(304);
    chk("rel6.down", 32'(key_down), 32'h0);
    keys[12] = 1'b1;
    exp_q.push_back(4'd12);
    goto_edge(336);
    flags("p12", 1'b1, 1'b1, 1'b0);
    pop_chk("p12.code");
    keys    = '0;
    key_ack = 1'b1;
    goto_edge(337);
    key_ack = 1'b0;
    chk("p12.ack_valid", 32'(key_valid), 32'h0);
    goto_edge(368);
    chk("rel12.down", 32'(key_down), 32'h0);

    // ghosting: codes 1 and 4 together, then drop code 4
    keys[1] = 1'b1;
    keys[4] = 1'b1;
    for (int f = 24; f <= 29; f++) begin
      goto_edge(16 * f);
      flags("ghost", 1'b0, 1'b0, 1'b0);
    end
    keys[4] = 1'b0;
    exp_q.push_back(4'd1);
    goto_edge(495);
    chk("p1.early_valid", 32'(key_valid), 32'h0);
    goto_edge(496);
    flags("p1", 1'b1, 1'b1, 1'b0);
    pop_chk("p1.code");
    keys    = '0;
    key_ack = 1'b1;
    goto_edge(497);
    key_ack = 1'b0;
    chk("p1.ack_valid", 32'(key_valid), 32'h0);
    goto_edge(528);
    chk("rel1.down", 32'(key_down), 32'h0);

    // overrun: code 3 then code 9 with no ack in between
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    goto_edge(560);
    flags("p3", 1'b1, 1'b1, 1'b0);
    pop_chk("p3.code");
    keys = '0;
    goto_edge(592);
    chk("rel3.down", 32'(key_down), 32'h0);
    keys[9] = 1'b1;
    goto_edge(623);
    chk("p9.pre_overrun", 32'(overrun), 32'h0);
    goto_edge(624);
    flags("p9", 1'b1, 1'b1, 1'b1);
    chk("p9.code_kept", 32'(key_code), 32'h3);
    key_ack = 1'b1;
    goto_edge(625);
    key_ack = 1'b0;
    chk("p9.ack_valid", 32'(key_valid), 32'h0);
    chk("p9.ack_overrun", 32'(overrun), 32'h0);
    keys = '0;
    goto_edge(656);
    chk("rel9.down", 32'(key_down), 32'h0);

    // reset mid-frame while an event is held
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    goto_edge(688);
    flags("p6b", 1'b1, 1'b1, 1'b0);
    pop_chk("p6b.code");
    goto_edge(690);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst.col", 32'(col), 32'h7);
    chk("mrst.key_code", 32'(key_code), 32'h0);
    flags("mrst", 1'b0, 1'b0, 1'b0);
    keys = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_edge(3);
    chk("restart.col0", 32'(col), 32'h7);
    goto_edge(4);
    chk("restart.col1", 32'(col), 32'hB);
    flags("restart", 1'b0, 1'b0, 1'b0);

    chk("scoreboard.empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the 7-segment digit multiplexer: scans a 4x4 matrix keypad by driving one column low at a time and reading the rows.
- Debounces across whole scan frames.
- Delivers each new key press as a 4-bit code through a valid/ack holding register.
- Sits beside the display driver on the board top level and feeds the CPU debug/step logic.

Parameters:
- SCAN_DIV, 65536, clk cycles each column is driven before its rows are sampled (must be >= 4).
- DEBOUNCE_CNT, 4, consecutive identical frames required to accept a press or a release (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  4  keypad rows, active-low (pulled up; 0 = key closed on the driven column)
- col  out  4  column drive, one-hot active-low
- key_code  out  4  code of the held key event, code = col_index*4 + row_index
- key_valid  out  1  key_code holds an unconsumed event
- key_ack  in  1  consumer accepts key_code; only meaningful while key_valid=1
- key_down  out  1  debounced level: a single key is currently accepted as pressed
- overrun  out  1  sticky: a new event arrived while key_valid=1 with no ack

Behaviour:
- Reset (async assert, sync release) values:
  - col=4'b0111, column index 0.
  - Divider 0; frame snapshot 0; prev_candidate=NONE; stable count 0; reported=0.
  - key_code=0, key_valid=0, key_down=0, overrun=0.
  - Synchroniser flops reset to 4'b1111.
- row passes through a 2-flop synchroniser before any use.
- Divider:
  - Counts 0..SCAN_DIV-1.
  - tick=1 on the cycle the count equals SCAN_DIV-1; the count then wraps to 0.
- On tick:
  - Store ~row_sync into snapshot bits [idx*4 +: 4].
  - Advance idx 0->1->2->3->0.
  - col follows idx: 0111, 1011, 1101, 1110.
- Frame end is the tick with idx=3. The candidate is computed from the completed 16-bit snapshot, including the column-3 sample taken that cycle:
  - Exactly one bit set: candidate = that bit index.
  - Zero bits set, or two or more set (ghosting): candidate = NONE.
- Debounce, evaluated at frame end:
  - candidate == prev_candidate: stable count increments, saturating at DEBOUNCE_CNT.
  - Otherwise: stable count = 1.
  - prev_candidate <= candidate.
- Accept press:
  - Condition: stable count becomes DEBOUNCE_CNT, candidate != NONE, reported=0.
  - Action: raise the internal event for 1 cycle; set reported=1 and key_down=1.
- Accept release:
  - Condition: stable count becomes DEBOUNCE_CNT with candidate = NONE.
  - Action: clear reported and key_down.
- Direct key-to-key change (A held, then B) is one frame of mismatch and resets the count to 1. B is not reported until a release has been accepted: exactly one event per press.
- Event latency: key_valid rises the cycle after the accepting frame-end tick.
- Holding register, per cycle:
  - event, key_valid=0: load code, key_valid<=1.
  - event, key_valid=1, key_ack=1: load new code, key_valid stays 1, overrun unchanged.
  - event, key_valid=1, key_ack=0: key_code keeps the old value, overrun<=1.
  - No event, key_valid=1, key_ack=1: key_valid<=0, overrun<=0.
  - key_ack while key_valid=0: ignored.
- key_code is stable while key_valid=1 and no ack occurs.
- Reset mid-frame: all state returns to reset values immediately. A partial snapshot is discarded and any pending event is lost.

Decomposition:
- Shared package:
  - COL_PATTERN[0..3] = 0111/1011/1101/1110.
  - KEY_NONE sentinel (5-bit candidate encoding, value 5'h10).
  - KEY_W=4.
- One sub-module, sync2_bus: a 2-flop, 4-bit synchroniser with reset value 4'b1111. It is reused for any future switch inputs.
- Divider, scan, debounce and holding register live in keypad_scan.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2, so one frame = 16 cycles):
1. Reset, then hold rows 1111 for 5 frames: col cycles 0111,1011,1101,1110, changing every 4 clk; key_valid, key_down and overrun stay 0.
2. Close key row 2 / col 1 (row=1011 whenever col=1011) from frame start:
   - key_valid=1 with key_code=6 one cycle after the second frame end.
   - key_down=1.
   - Hold 10 frames: no second event.
3. Case 2 with key_ack pulsed 3 cycles after key_valid: key_valid drops next cycle. Release the key for 2 frames: key_down=0. Press row 0 / col 3: key_code=12.
4. Two keys closed simultaneously (codes 1 and 4) for 6 frames: no event, key_down=0. Then release code 4 only: code 1 is reported after 2 frames.
5. Two separate presses (codes 3 then 9, each with a proper release) with no ack: key_code stays 3 and overrun=1. Then ack: key_valid=0, overrun=0.
6. Assert rst_n=0 mid-frame while key_valid=1: outputs return to reset values within the same cycle. After release, scanning restarts at col=0111.
